recirc_xfer_scheduler: RTL



---
 rtl/recirc_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/recirc_xfer_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/recirc_sched_pkg.sv
// Shared types and width helpers for the recirculation transfer scheduler.
//   sched_state_t : scheduler FSM encoding (IDLE -> PULSE -> HOLD -> IDLE)
//   id_width()    : width of a requester index (at least 1 bit)
//   cnt_width()   : width of the hold counter, able to hold G_HOLD_CYCLES
package recirc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } sched_state_t;

  localparam int DEF_REQ         = 4;
  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 8;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_width(input int hold_cycles);
    return (hold_cycles > 0) ? $clog2(hold_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req      : per-requester request vector
//   i_last     : index of the previously granted requester
//   o_grant    : one-hot winner (all zero when no request)
//   o_grant_id : index of the winner (0 when no request)
// The search starts at i_last+1 and wraps modulo G_REQ, so the last winner
// is considered last; a lone requester still wins every time.
module rr_arbiter
  import recirc_sched_pkg::*;
#(
  parameter int G_REQ = DEF_REQ
) (
  input  logic [G_REQ-1:0]           i_req,
  input  logic [id_width(G_REQ)-1:0] i_last,
  output logic [G_REQ-1:0]           o_grant,
  output logic [id_width(G_REQ)-1:0] o_grant_id
);

  localparam int ID_W = id_width(G_REQ);

  int  idx;
  logic found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = 0;
    for (int off = 1; off <= G_REQ; off++) begin
      idx = (int'(i_last) + off) % G_REQ;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/recirc_xfer_scheduler.sv
// Source-domain scheduler sharing one recirculation-mux CDC channel.
//   i_clk      : source clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_valid    : per-requester request
//   i_data     : requester words, requester k at [k*G_WIDTH +: G_WIDTH]
//   o_ready    : one-hot accept (combinational, only in IDLE)
//   o_pulse    : single-cycle launch pulse to the toggle synchronizer
//   o_data     : held word for the mux data input
//   o_grant_id : requester whose word is in o_data
//   o_busy     : high in PULSE and HOLD
//
// Handshake: a transfer happens on a cycle where i_valid[k] & o_ready[k].
// o_ready depends only on i_valid and registered state/pointer, never the
// reverse, and the requester need not hold i_valid/i_data after acceptance.
module recirc_xfer_scheduler
  import recirc_sched_pkg::*;
#(
  parameter int G_REQ         = DEF_REQ,
  parameter int G_WIDTH       = DEF_WIDTH,
  parameter int G_HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [G_REQ-1:0]             i_valid,
  input  logic [G_REQ*G_WIDTH-1:0]     i_data,
  output logic [G_REQ-1:0]             o_ready,
  output logic                         o_pulse,
  output logic [G_WIDTH-1:0]           o_data,
  output logic [id_width(G_REQ)-1:0]   o_grant_id,
  output logic                         o_busy
);

  localparam int ID_W  = id_width(G_REQ);
  localparam int CNT_W = cnt_width(G_HOLD_CYCLES);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [G_WIDTH-1:0] data_q;
  logic [ID_W-1:0]   gid_q;
  logic [ID_W-1:0]   last_q;

  logic [G_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_id;
  logic              handshake;

  rr_arbiter #(.G_REQ(G_REQ)) u_arb (
    .i_req      (i_valid),
    .i_last     (last_q),
    .o_grant    (arb_grant),
    .o_grant_id (arb_id)
  );

  // Ready is also masked by reset so nothing looks accepted while the
  // block is being held in reset with requests pending.
  assign o_ready   = (state_q == IDLE && i_rst_n) ? arb_grant : '0;
  assign handshake = |o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) state_d = PULSE;
      end
      PULSE: begin
        state_d = HOLD;
        cnt_d   = CNT_W'(G_HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(G_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Word, id and pointer move only on an accepted request; otherwise
      // the mux sees a frozen word, including while idle.
      if (handshake) begin
        data_q <= i_data[arb_id*G_WIDTH +: G_WIDTH];
        gid_q  <= arb_id;
        last_q <= arb_id;
      end
    end
  end

  assign o_pulse    = (state_q == PULSE);
  assign o_busy     = (state_q != IDLE);
  assign o_data     = data_q;
  assign o_grant_id = gid_q;

endmodule
